// File: rtl/deser_pkg.sv
// -----------------------------------------------------------------------------
// deser_pkg
// Shared definitions for the deserializer packet sequencer:
//   - seq_state_t : sequencer state encoding (IDLE, ARM, COLLECT, HOLD)
//   - DEF_*       : default word/packet widths and watchdog limit
//   - cnt_width() : width of a counter indexing n items, never below 1 bit
// -----------------------------------------------------------------------------
package deser_pkg;

    localparam int DEF_WORD_SIZE      = 8;
    localparam int DEF_DATA_LENGTH    = 16;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_COLLECT = 2'd2,
        ST_HOLD    = 2'd3
    } seq_state_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/deser_watchdog.sv
// -----------------------------------------------------------------------------
// deser_watchdog
// Loadable down-counter. Reloads to LOAD_VALUE on `load`, decrements while
// `count_en` is high and pulses `expire` in the cycle it steps from 1 to 0.
// A load in the same cycle as a count takes priority (no expire).
//
// Ports:
//   clock    in  : rising-edge clock
//   reset    in  : asynchronous, active-low reset (counter cleared)
//   load     in  : reload counter to LOAD_VALUE
//   count_en in  : decrement enable
//   expire   out : one-cycle pulse when the count runs out
// -----------------------------------------------------------------------------
module deser_watchdog #(
    parameter int LOAD_VALUE = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic count_en,
    output logic expire
);

    localparam int CW = $clog2(LOAD_VALUE + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        expire = 1'b0;
        if (load) begin
            cnt_d = CW'(LOAD_VALUE);
        end else if (count_en && (cnt_q != '0)) begin
            cnt_d  = cnt_q - CW'(1);
            expire = (cnt_q == CW'(1));
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/deser_packet_sequencer.sv
// -----------------------------------------------------------------------------
// deser_packet_sequencer
// Sequences an external word deserializer: pulses its start, collects
// DATA_LENGTH/WORD_SIZE words (first word in the MSBs) into one packet
// register and offers the packet downstream.
//
// Handshake: pkt_valid/pkt_ready -- a packet transfers on a rising edge where
// both are high; pkt_valid stays high and pkt_data stays stable until then,
// and pkt_ready may be high before pkt_valid rises.
//
// Optional feature macro: DESER_SEQ_TIMEOUT_EN adds a watchdog that aborts a
// stalled COLLECT after TIMEOUT_CYCLES and sets timeout_err. Without it the
// sequencer waits indefinitely and timeout_err is tied low.
//
// Ports:
//   clock, reset       : clock (rising edge), async active-low reset
//   enable             : permits new deserializer runs
//   err_clr            : pulse clearing the sticky error flags
//   deser_busy         : deserializer busy
//   deser_rco          : deserializer word-complete pulse
//   deser_data         : deserializer word, valid with deser_rco
//   deser_start        : one-cycle start pulse to the deserializer
//   pkt_data/pkt_valid : assembled packet and its valid flag
//   pkt_ready          : consumer accepts the packet
//   active             : high outside IDLE
//   overrun            : sticky, word arrived when none was expected
//   timeout_err        : sticky, run aborted by the watchdog
//   state_dbg          : current sequencer state (seq_state_t encoding)
// -----------------------------------------------------------------------------
module deser_packet_sequencer
    import deser_pkg::*;
#(
    parameter int DATA_LENGTH    = DEF_DATA_LENGTH,
    parameter int WORD_SIZE      = DEF_WORD_SIZE,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   err_clr,
    input  logic                   deser_busy,
    input  logic                   deser_rco,
    input  logic [WORD_SIZE-1:0]   deser_data,
    output logic                   deser_start,
    output logic [DATA_LENGTH-1:0] pkt_data,
    output logic                   pkt_valid,
    input  logic                   pkt_ready,
    output logic                   active,
    output logic                   overrun,
    output logic                   timeout_err,
    output logic [1:0]             state_dbg
);

    localparam int WORDS  = DATA_LENGTH / WORD_SIZE;
    localparam int WCNT_W = cnt_width(WORDS);
    localparam logic [WCNT_W-1:0] LAST_WCNT = WCNT_W'(WORDS - 1);

    seq_state_t             state_q;
    seq_state_t             state_d;
    logic [WCNT_W-1:0]      wcnt_q;
    logic [WCNT_W-1:0]      wcnt_d;
    logic [DATA_LENGTH-1:0] pkt_data_q;
    logic [DATA_LENGTH-1:0] pkt_data_d;
    logic                   overrun_q;
    logic                   overrun_d;

    logic overrun_set;
    logic timeout_set;
    logic wd_load;
    logic wd_count;
    logic wd_expire;

    // Next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        pkt_data_d  = pkt_data_q;
        overrun_set = 1'b0;
        timeout_set = 1'b0;
        wd_load     = 1'b0;
        wd_count    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                overrun_set = deser_rco;
                if (enable && !deser_busy) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                overrun_set = deser_rco;
                wcnt_d      = '0;
                wd_load     = 1'b1;
                state_d     = ST_COLLECT;
            end
            ST_COLLECT: begin
                wd_count = 1'b1;
                if (deser_rco) begin
                    wd_load = 1'b1;
                    // Slot 0 is the MSB word; a constant-indexed loop keeps
                    // the write a plain mux per slot.
                    for (int i = 0; i < WORDS; i++) begin
                        if (wcnt_q == WCNT_W'(i)) begin
                            pkt_data_d[DATA_LENGTH-1-i*WORD_SIZE -: WORD_SIZE] = deser_data;
                        end
                    end
                    if (wcnt_q == LAST_WCNT) begin
                        state_d = ST_HOLD;
                    end else begin
                        wcnt_d = wcnt_q + WCNT_W'(1);
                    end
                end else if (wd_expire) begin
                    // Stalled run: drop the partial packet, never offer it.
                    timeout_set = 1'b1;
                    pkt_data_d  = '0;
                    state_d     = ST_IDLE;
                end
            end
            ST_HOLD: begin
                overrun_set = deser_rco;
                if (pkt_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new error in the clearing cycle wins over the clear.
        overrun_d = (overrun_q && !err_clr) || overrun_set;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            wcnt_q     <= '0;
            pkt_data_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            pkt_data_q <= pkt_data_d;
            overrun_q  <= overrun_d;
        end
    end

`ifdef DESER_SEQ_TIMEOUT_EN
    logic timeout_q;
    logic timeout_d;

    deser_watchdog #(
        .LOAD_VALUE(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .load    (wd_load),
        .count_en(wd_count),
        .expire  (wd_expire)
    );

    always_comb begin
        timeout_d = (timeout_q && !err_clr) || timeout_set;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign timeout_err = timeout_q;
`else
    logic unused_watchdog;

    assign wd_expire       = 1'b0;
    assign timeout_err     = 1'b0;
    assign unused_watchdog = wd_load ^ wd_count ^ timeout_set ^ (TIMEOUT_CYCLES == 0);
`endif

    // Outputs are decodes of registered state only, so no input reaches an
    // output combinationally.
    assign deser_start = (state_q == ST_ARM);
    assign pkt_valid   = (state_q == ST_HOLD);
    assign active      = (state_q != ST_IDLE);
    assign pkt_data    = pkt_data_q;
    assign overrun     = overrun_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_deser_packet_sequencer.sv
`timescale 1ns/1ps
module tb_deser_packet_sequencer;

    localparam int DL    = 16;
    localparam int WS    = 8;
    localparam int WORDS = DL / WS;

    logic          clock       = 1'b0;
    logic          reset       = 1'b0;
    logic          enable      = 1'b0;
    logic          err_clr     = 1'b0;
    logic          deser_busy  = 1'b0;
    logic          deser_rco   = 1'b0;
    logic [WS-1:0] deser_data  = '0;
    logic          pkt_ready   = 1'b0;
    logic          deser_start;
    logic [DL-1:0] pkt_data;
    logic          pkt_valid;
    logic          active;
    logic          overrun;
    logic          timeout_err;
    logic [1:0]    state_dbg;

    int checks     = 0;
    int errors     = 0;
    int start_cnt  = 0;
    int xfer_cnt   = 0;
    int push_cnt   = 0;
    int valid_cyc  = 0;
    bit rand_ready = 1'b0;

    logic [DL-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    deser_packet_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .err_clr    (err_clr),
        .deser_busy (deser_busy),
        .deser_rco  (deser_rco),
        .deser_data (deser_data),
        .deser_start(deser_start),
        .pkt_data   (pkt_data),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .active     (active),
        .overrun    (overrun),
        .timeout_err(timeout_err),
        .state_dbg  (state_dbg)
    );

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Returns at the falling edge where deser_start is seen high.
    task automatic wait_start(input int max_cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(negedge clock);
            if (deser_start) seen = 1'b1;
        end
        check("start_seen", 64'(seen), 64'd1);
    endtask

    task automatic send_word(input logic [WS-1:0] w);
        deser_rco  = 1'b1;
        deser_data = w;
        tick();
        deser_rco  = 1'b0;
        deser_data = WS'($urandom);
    endtask

    // Feeds the words of `words` (most significant word first) and queues
    // the packet the reference model expects: words concatenated in arrival order.
    task automatic run_packet(input logic [DL-1:0] words, input bit gaps);
        logic [DL-1:0] acc;
        logic [WS-1:0] w;
        acc        = '0;
        deser_busy = 1'b1;
        for (int i = 0; i < WORDS; i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) tick();
            w   = words[DL-1-i*WS -: WS];
            acc = (acc << WS) | DL'(w);
            send_word(w);
        end
        exp_q.push_back(acc);
        push_cnt++;
        deser_busy = 1'b0;
    endtask

    // Consumer readiness toggled randomly during the random phase.
    always @(posedge clock) begin
        if (rand_ready) begin
            #1;
            pkt_ready = ($urandom_range(0, 99) < 60);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        if (reset) begin
            if (deser_start) begin
                start_cnt++;
                check("no_start_while_valid", 64'(pkt_valid), 64'd0);
            end
            if (pkt_valid) begin
                valid_cyc++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pkt: got 0x%0h expected no packet", pkt_data);
                end else begin
                    check("pkt_data", 64'(pkt_data), 64'(exp_q[0]));
                    if (pkt_ready) begin
                        void'(exp_q.pop_front());
                        xfer_cnt++;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int            s0;
        int            v0;
        logic [DL-1:0] rw;

        // Reset values
        repeat (2) @(negedge clock);
        check("rst_start",   64'(deser_start), 64'd0);
        check("rst_valid",   64'(pkt_valid),   64'd0);
        check("rst_data",    64'(pkt_data),    64'd0);
        check("rst_active",  64'(active),      64'd0);
        check("rst_overrun", 64'(overrun),     64'd0);
        check("rst_timeout", 64'(timeout_err), 64'd0);
        check("rst_state",   64'(state_dbg),   64'd0);

        // Basic packet 0x51, 0xB1
        @(posedge clock); #1;
        reset  = 1'b1;
        enable = 1'b1;
        wait_start(10);
        tick();
        check("start_one_cycle", 64'(deser_start), 64'd0);
        deser_busy = 1'b1;
        send_word(8'h51);
        send_word(8'hB1);
        deser_busy = 1'b0;
        exp_q.push_back(16'h51B1);
        push_cnt++;
        @(negedge clock);
        check("valid_after_last_rco", 64'(pkt_valid), 64'd1);

        // Long hold with overrun injection and error clearing
        s0 = start_cnt;
        repeat (10) tick();
        send_word(8'hAA);
        @(negedge clock);
        check("overrun_set", 64'(overrun), 64'd1);
        tick();
        err_clr    = 1'b1;
        deser_rco  = 1'b1;
        deser_data = 8'h55;
        tick();
        err_clr   = 1'b0;
        deser_rco = 1'b0;
        @(negedge clock);
        check("overrun_clr_vs_event", 64'(overrun), 64'd1);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clock);
        check("overrun_cleared", 64'(overrun), 64'd0);
        repeat (5) tick();
        check("no_start_in_hold", 64'(start_cnt), 64'(s0));
        check("hold_still_valid", 64'(pkt_valid), 64'd1);

        // Transfer and restart timing
        pkt_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("valid_drop", 64'(pkt_valid), 64'd0);
        check("no_start_1_after_xfer", 64'(deser_start), 64'd0);
        @(negedge clock);
        check("start_2_after_xfer", 64'(deser_start), 64'd1);

        // Enable dropped during COLLECT: packet still delivered, no new run
        tick();
        enable = 1'b0;
        s0     = start_cnt;
        rw     = DL'($urandom);
        run_packet(rw, 1'b1);
        repeat (10) tick();
        check("no_start_after_enable_low", 64'(start_cnt), 64'(s0));
        check("enable_low_delivered", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of a run
        pkt_ready = 1'b0;
        enable    = 1'b1;
        wait_start(10);
        tick();
        deser_busy = 1'b1;
        send_word(8'h51);
        reset      = 1'b0;
        #1;
        check("mid_rst_start",   64'(deser_start), 64'd0);
        check("mid_rst_valid",   64'(pkt_valid),   64'd0);
        check("mid_rst_data",    64'(pkt_data),    64'd0);
        check("mid_rst_active",  64'(active),      64'd0);
        check("mid_rst_overrun", 64'(overrun),     64'd0);
        check("mid_rst_state",   64'(state_dbg),   64'd0);
        deser_busy = 1'b0;
        repeat (3) @(negedge clock);
        check("mid_rst_held_start", 64'(deser_start), 64'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        wait_start(10);
        tick();
        enable     = 1'b0;
        deser_busy = 1'b1;
        send_word(8'h12);
        send_word(8'h34);
        deser_busy = 1'b0;
        exp_q.push_back(16'h1234);
        push_cnt++;
        pkt_ready = 1'b1;
        repeat (4) tick();
        check("rst_recovery_delivered", 64'(exp_q.size()), 64'd0);

        // Stalled run
        pkt_ready = 1'b0;
        enable    = 1'b1;
        wait_start(10);
        tick();
        enable     = 1'b0;
        deser_busy = 1'b1;
        v0         = valid_cyc;
        repeat (70) tick();
`ifdef DESER_SEQ_TIMEOUT_EN
        check("timeout_flag",     64'(timeout_err), 64'd1);
        check("timeout_idle",     64'(active),      64'd0);
        check("timeout_state",    64'(state_dbg),   64'd0);
        check("timeout_no_valid", 64'(valid_cyc),   64'(v0));
        deser_busy = 1'b0;
        err_clr    = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clock);
        check("timeout_cleared", 64'(timeout_err), 64'd0);
`else
        check("stall_active",     64'(active),      64'd1);
        check("stall_no_timeout", 64'(timeout_err), 64'd0);
        check("stall_no_valid",   64'(valid_cyc),   64'(v0));
        rw = DL'($urandom);
        run_packet(rw, 1'b0);
        pkt_ready = 1'b1;
        repeat (3) tick();
`endif

        // Random phase
        enable     = 1'b1;
        rand_ready = 1'b1;
        for (int p = 0; p < 25; p++) begin
            wait_start(300);
            tick();
            rw = DL'($urandom);
            run_packet(rw, 1'b1);
        end
        enable     = 1'b0;
        rand_ready = 1'b0;
        tick();
        pkt_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
        check("queue_drained",  64'(exp_q.size()), 64'd0);
        check("transfer_count", 64'(xfer_cnt),     64'(push_cnt));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
